// File: rtl/decoder_rr_arbiter_if.sv
// Purpose: bundles the request/grant signals between the requesters and
//          decoder_rr_arbiter.
// Signals:
//   req     [15:0]  request vector, req[i] = 1 when requester i wants the resource
//   K       [3:0]   index of the current owner (registered)
//   enable          1 while a grant is active (registered)
//   grant   [15:0]  one-hot decoder output for K/enable, zero when enable = 0
//   timeout         one-cycle pulse on a forced release (hold-limit builds only)
// Modports:
//   master  requester side: drives req, observes the grant side
//   slave   arbiter side: samples req, drives K/enable/grant/timeout
// Handshake: a requester holds req[i] high for as long as it wants the
//   resource; ownership starts the cycle after an edge where the arbiter
//   samples req[i] = 1 and picks i, and ends the cycle after the owner is
//   sampled with req[i] = 0 (or is preempted).
interface decoder_rr_arbiter_if;
   logic [15:0] req;
   logic [3:0]  K;
   logic        enable;
   logic [15:0] grant;
   logic        timeout;

   modport master (output req, input K, enable, grant, timeout);
   modport slave  (input req, output K, enable, grant, timeout);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Purpose: round-robin arbiter that sequences K/enable for a shared 4-to-16
//          decoder select path among 16 requesters and presents the one-hot
//          grant word for the chosen K/enable pair. A one-cycle dead (GAP)
//          cycle separates consecutive owners.
// Ports:
//   clk      in   single clock, rising-edge
//   rst      in   synchronous active-high reset
//   arb      slave modport of decoder_rr_arbiter_if (req in; K, enable,
//            grant, timeout out)
//   state_o  out  current FSM state (debug)
// Parameters:
//   MAX_HOLD  max consecutive grant cycles per owner, >= 1; only used when
//             ARB_HOLD_LIMIT_EN is defined.
// Configuration macro:
//   ARB_HOLD_LIMIT_EN  when defined, an owner still requesting after MAX_HOLD
//                      grant cycles is forcibly released and timeout pulses.
//                      When undefined, owners keep the grant until they drop
//                      req and timeout is tied to 0.
module decoder_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   decoder_rr_arbiter_if.slave        arb,
   output logic [1:0]                 state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("decoder_rr_arbiter: MAX_HOLD must be >= 1");
   end

   state_t      state_q;
   logic [3:0]  k_q;
   logic        en_q;
   logic [15:0] grant_q;
   logic [3:0]  ptr_q;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
   logic [HOLD_W-1:0] hold_cnt_q;
   logic              timeout_q;
`endif

   // Round-robin search starting at ptr_q; the 4-bit index wraps naturally.
   logic       found;
   logic [3:0] winner;
   logic [3:0] idx;

   always_comb begin
      found  = 1'b0;
      winner = 4'd0;
      idx    = 4'd0;
      for (int j = 0; j < 16; j++) begin
         idx = ptr_q + 4'(j);
         if (!found && arb.req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         k_q        <= 4'd0;
         en_q       <= 1'b0;
         grant_q    <= 16'h0000;
         ptr_q      <= 4'd0;
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
`ifdef ARB_HOLD_LIMIT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE, GAP: begin
               if (found) begin
                  state_q <= GRANT;
                  k_q     <= winner;
                  en_q    <= 1'b1;
                  grant_q <= 16'd1 << winner;
`ifdef ARB_HOLD_LIMIT_EN
                  hold_cnt_q <= HOLD_W'(1);
`endif
               end else begin
                  // K deliberately keeps its last value while idle.
                  state_q <= IDLE;
                  en_q    <= 1'b0;
                  grant_q <= 16'h0000;
               end
            end
            GRANT: begin
               if (!arb.req[k_q]) begin
                  state_q <= GAP;
                  en_q    <= 1'b0;
                  grant_q <= 16'h0000;
                  ptr_q   <= k_q + 4'd1;
               end
`ifdef ARB_HOLD_LIMIT_EN
               else if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
                  // Preempt a long-running owner; it rejoins in its RR turn.
                  state_q   <= GAP;
                  en_q      <= 1'b0;
                  grant_q   <= 16'h0000;
                  ptr_q     <= k_q + 4'd1;
                  timeout_q <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
               end
`endif
            end
            default: begin
               state_q <= IDLE;
               en_q    <= 1'b0;
               grant_q <= 16'h0000;
            end
         endcase
      end
   end

   assign arb.K      = k_q;
   assign arb.enable = en_q;
   assign arb.grant  = grant_q;
`ifdef ARB_HOLD_LIMIT_EN
   assign arb.timeout = timeout_q;
`else
   assign arb.timeout = 1'b0;
`endif
   assign state_o    = state_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
module tb_decoder_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   int         n_cmp;
   int         n_err;

   decoder_rr_arbiter_if arb_if ();

   decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .arb     (arb_if.slave),
      .state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner index, priority pointer, grant age.
   bit m_en;
   int m_k;
   int m_ptr;
   bit m_to;
   int m_hold;

   task automatic model_edge(input logic [15:0] r, input logic rs);
      if (rs) begin
         m_en = 0; m_k = 0; m_ptr = 0; m_to = 0; m_hold = 0;
         return;
      end
      m_to = 0;
      if (m_en) begin
         if (!r[m_k]) begin
            m_en  = 0;
            m_ptr = (m_k + 1) % 16;
         end
`ifdef ARB_HOLD_LIMIT_EN
         else if (m_hold == MAX_HOLD) begin
            m_en  = 0;
            m_to  = 1;
            m_ptr = (m_k + 1) % 16;
         end else begin
            m_hold = m_hold + 1;
         end
`endif
      end else begin
         for (int j = 0; j < 16; j++) begin
            if (!m_en && r[(m_ptr + j) % 16]) begin
               m_en   = 1;
               m_k    = (m_ptr + j) % 16;
               m_hold = 1;
            end
         end
      end
   endtask

   function automatic logic [15:0] model_grant();
      logic [15:0] one;
      one = 16'h0001;
      return m_en ? (one << m_k) : 16'h0000;
   endfunction

   // driver: apply req/rst for one edge, advance the model, settle
   task automatic cycle(input logic [15:0] r, input logic rs);
      @(negedge clk);
      arb_if.req = r;
      rst        = rs;
      @(posedge clk);
      model_edge(r, rs);
      #1;
   endtask

   task automatic test_reset();
      cycle(16'hFFFF, 1'b1);
      cycle(16'hFFFF, 1'b1);
      n_cmp++; if (arb_if.enable !== 1'b0) begin n_err++; $display("FAIL reset_enable got %b want 0", arb_if.enable); end
      n_cmp++; if (arb_if.grant !== 16'h0000) begin n_err++; $display("FAIL reset_grant got %h want 0000", arb_if.grant); end
      n_cmp++; if (arb_if.K !== 4'd0) begin n_err++; $display("FAIL reset_K got %0d want 0", arb_if.K); end
      n_cmp++; if (arb_if.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", arb_if.timeout); end
   endtask

   task automatic test_simple_grant();
      cycle(16'h0010, 1'b0);
      n_cmp++; if (arb_if.K !== 4'd4 || arb_if.enable !== 1'b1 || arb_if.grant !== 16'h0010) begin
         n_err++; $display("FAIL simple_grant got K=%0d en=%b g=%h want K=4 en=1 g=0010", arb_if.K, arb_if.enable, arb_if.grant);
      end
      cycle(16'h0000, 1'b0);
      n_cmp++; if (arb_if.enable !== 1'b0 || arb_if.grant !== 16'h0000) begin
         n_err++; $display("FAIL simple_gap got en=%b g=%h want en=0 g=0000", arb_if.enable, arb_if.grant);
      end
      cycle(16'h0000, 1'b0);
      n_cmp++; if (arb_if.enable !== 1'b0 || arb_if.K !== 4'd4) begin
         n_err++; $display("FAIL simple_idle got en=%b K=%0d want en=0 K=4", arb_if.enable, arb_if.K);
      end
   endtask

   task automatic test_rotation();
      int exp_k [4] = '{0, 15, 0, 15};
      logic [15:0] one;
      one = 16'h0001;
      cycle(16'h0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(16'h8001, 1'b0);
         n_cmp++; if (arb_if.enable !== 1'b1 || arb_if.K !== 4'(exp_k[i]) || arb_if.grant !== (one << exp_k[i])) begin
            n_err++; $display("FAIL rotation_%0d got K=%0d en=%b g=%h want K=%0d en=1", i, arb_if.K, arb_if.enable, arb_if.grant, exp_k[i]);
         end
         cycle(16'h8001 & ~(one << exp_k[i]), 1'b0);
         n_cmp++; if (arb_if.enable !== 1'b0 || arb_if.grant !== 16'h0000) begin
            n_err++; $display("FAIL rotation_gap_%0d got en=%b g=%h want en=0 g=0000", i, arb_if.enable, arb_if.grant);
         end
      end
   endtask

   task automatic test_wrap();
      cycle(16'h0000, 1'b1);
      cycle(16'h4000, 1'b0);
      cycle(16'h0000, 1'b0);
      cycle(16'h4001, 1'b0);
      n_cmp++; if (arb_if.K !== 4'd0 || arb_if.grant !== 16'h0001) begin
         n_err++; $display("FAIL wrap got K=%0d g=%h want K=0 g=0001", arb_if.K, arb_if.grant);
      end
      cycle(16'h0000, 1'b0);
   endtask

   task automatic test_reset_mid();
      cycle(16'h0000, 1'b1);
      cycle(16'h0200, 1'b0);
      n_cmp++; if (arb_if.K !== 4'd9 || arb_if.enable !== 1'b1) begin
         n_err++; $display("FAIL mid_pre got K=%0d en=%b want K=9 en=1", arb_if.K, arb_if.enable);
      end
      cycle(16'h0200, 1'b1);
      n_cmp++; if (arb_if.enable !== 1'b0 || arb_if.grant !== 16'h0000 || arb_if.K !== 4'd0) begin
         n_err++; $display("FAIL mid_reset got en=%b g=%h K=%0d want en=0 g=0000 K=0", arb_if.enable, arb_if.grant, arb_if.K);
      end
      cycle(16'h0200, 1'b0);
      n_cmp++; if (arb_if.K !== 4'd9 || arb_if.grant !== 16'h0200) begin
         n_err++; $display("FAIL mid_regrant got K=%0d g=%h want K=9 g=0200", arb_if.K, arb_if.grant);
      end
   endtask

   task automatic test_handover_and_pulse();
      cycle(16'h0000, 1'b1);
      cycle(16'h0001, 1'b0);
      // owner drops while requester 5 rises: GAP, then 5
      cycle(16'h0020, 1'b0);
      n_cmp++; if (arb_if.enable !== 1'b0) begin n_err++; $display("FAIL handover_gap got en=%b want 0", arb_if.enable); end
      cycle(16'h0020, 1'b0);
      n_cmp++; if (arb_if.K !== 4'd5 || arb_if.enable !== 1'b1) begin
         n_err++; $display("FAIL handover got K=%0d en=%b want K=5 en=1", arb_if.K, arb_if.enable);
      end
      // requester 2 seen only on the edge that releases 5, gone at arbitration
      cycle(16'h0004, 1'b0);
      cycle(16'h0000, 1'b0);
      n_cmp++; if (arb_if.enable !== 1'b0 || arb_if.K !== 4'd5) begin
         n_err++; $display("FAIL gap_pulse got en=%b K=%0d want en=0 K=5", arb_if.enable, arb_if.K);
      end
      // sole requester re-requesting after its own release
      cycle(16'h0008, 1'b0);
      cycle(16'h0000, 1'b0);
      cycle(16'h0008, 1'b0);
      n_cmp++; if (arb_if.K !== 4'd3 || arb_if.enable !== 1'b1) begin
         n_err++; $display("FAIL sole_regrant got K=%0d en=%b want K=3 en=1", arb_if.K, arb_if.enable);
      end
   endtask

   task automatic test_hold_limit();
      int n_to;
      n_to = 0;
      cycle(16'h0000, 1'b1);
      for (int i = 0; i < 40; i++) begin
         cycle(16'h0006, 1'b0);
         if (arb_if.timeout === 1'b1) n_to++;
         n_cmp++; if (arb_if.K !== 4'(m_k) || arb_if.enable !== m_en || arb_if.timeout !== m_to) begin
            n_err++; $display("FAIL hold_%0d got K=%0d en=%b to=%b want K=%0d en=%b to=%b",
                              i, arb_if.K, arb_if.enable, arb_if.timeout, m_k, m_en, m_to);
         end
`ifndef ARB_HOLD_LIMIT_EN
         n_cmp++; if (arb_if.K !== 4'd1 || arb_if.enable !== 1'b1) begin
            n_err++; $display("FAIL hold_forever_%0d got K=%0d en=%b want K=1 en=1", i, arb_if.K, arb_if.enable);
         end
`endif
      end
`ifdef ARB_HOLD_LIMIT_EN
      n_cmp++; if (n_to < 3) begin n_err++; $display("FAIL hold_timeouts got %0d want >=3", n_to); end
`else
      n_cmp++; if (n_to != 0) begin n_err++; $display("FAIL hold_timeouts got %0d want 0", n_to); end
`endif
   endtask

   task automatic test_random();
      logic [15:0] r;
      logic [15:0] flip;
      logic        rs;
      r = 16'h0000;
      cycle(16'h0000, 1'b1);
      for (int i = 0; i < 500; i++) begin
         flip = 16'h0000;
         for (int b = 0; b < 16; b++) flip[b] = ($urandom_range(0, 7) == 0);
         r  = r ^ flip;
         rs = ($urandom_range(0, 99) == 0);
         cycle(r, rs);
         n_cmp++; if (arb_if.K !== 4'(m_k) || arb_if.enable !== m_en || arb_if.grant !== model_grant() || arb_if.timeout !== m_to) begin
            n_err++; $display("FAIL random_%0d got K=%0d en=%b g=%h to=%b want K=%0d en=%b g=%h to=%b",
                              i, arb_if.K, arb_if.enable, arb_if.grant, arb_if.timeout, m_k, m_en, model_grant(), m_to);
         end
         n_cmp++; if (!$onehot0(arb_if.grant) || ((arb_if.grant != 16'h0000) !== arb_if.enable)) begin
            n_err++; $display("FAIL random_inv_%0d got g=%h en=%b want onehot0 and nonzero iff en", i, arb_if.grant, arb_if.enable);
         end
      end
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b1;
      arb_if.req = 16'h0000;
      test_reset();
      test_simple_grant();
      test_rotation();
      test_wrap();
      test_reset_mid();
      test_handover_and_pulse();
      test_hold_limit();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
